// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
// Optional macro PIPE_STAGE_STATS_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              run,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);

  // State is exactly {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_v, skid_v;
  logic              active, in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;
  state_t            state, next_state;

  // Clear is folded in so both handshakes are low during the reset cycle too.
  assign active    = run & ~flush & ~clear;
  assign in_ready  = active & ~skid_v;
  assign out_valid = active & main_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign state     = state_t'({main_v, skid_v});

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          next_state   = BUSY;
          load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          next_state     = BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      {main_v, skid_v} <= next_state;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (run) begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!flush && !main_v && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
